sync_ram_arbiter: RTL
=====================

SYNC_RAM_ARBITER -- requirements
Module: sync_ram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 2, SHALL set the RAM address width.
REQ-002 Parameter DATA_W, default 8, SHALL set the RAM data width.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 Port clk, input, 1 bit, SHALL be the single clock; all state changes on its rising edge.
REQ-005 Port reset, input, 1 bit, SHALL be the synchronous active-high reset.
REQ-006 Ports req0/req1, input, 1 bit each, SHALL be the requester access requests.
REQ-007 Ports we0/we1, input, 1 bit each, SHALL select write (1) or read (0).
REQ-008 Ports addr0/addr1, input, ADDR_W each, SHALL carry the requested address.
REQ-009 Ports wdata0/wdata1, input, DATA_W each, SHALL carry the write data.
REQ-010 Ports gnt0/gnt1, output, 1 bit each, SHALL flag the current owner during ACCESS and RESP.
REQ-011 Ports ack0/ack1, output, 1 bit each, SHALL pulse for one cycle when that requester's transaction completes.
REQ-012 Ports rdata0/rdata1, output, DATA_W each, SHALL hold the last read result for that requester.
REQ-013 Ports ram_addr (ADDR_W), ram_din (DATA_W), ram_rd, ram_we, ram_cs (1 bit), outputs, SHALL drive the shared synchronous RAM.
REQ-014 Port ram_dout, input, DATA_W, SHALL be the RAM read data, valid the cycle after the read strobe.

Function
REQ-015 FSM states IDLE, ACCESS, RESP; every transaction SHALL take exactly 3 cycles from IDLE.
REQ-016 IDLE: if any req high, SHALL latch the winner's we/addr/wdata and go to ACCESS; otherwise stay in IDLE with all RAM strobes low.
REQ-017 Arbitration SHALL be round-robin: if both request, the requester other than last_owner wins; if one requests, it wins.
REQ-018 ACCESS: SHALL drive ram_cs=1, ram_addr=latched addr, and exactly one of ram_we (write, ram_din=latched wdata) or ram_rd (read) for one cycle, then go to RESP.
REQ-019 RESP: SHALL drop ram_cs/ram_rd/ram_we, pulse ack of the owner, load rdata of the owner from ram_dout on reads only, set last_owner=owner, and return to IDLE.
REQ-020 Writes SHALL leave rdata0/rdata1 unchanged.
REQ-021 Request fields SHALL be sampled only in IDLE; changes or req deassertion during ACCESS/RESP SHALL NOT abort or alter the transaction, and ack SHALL still be issued.
REQ-022 A req still high in the IDLE cycle after its ack SHALL be treated as a new request.
REQ-023 gnt0 and gnt1 SHALL never both be high; ram_we and ram_rd SHALL never both be high.

Reset
REQ-024 Reset SHALL force IDLE, last_owner=1 (requester 0 wins the first tie), all outputs 0 including rdata0/rdata1.
REQ-025 Reset asserted during ACCESS or RESP SHALL abandon the transaction with no ack and no further RAM strobe.

Configuration
REQ-026 Macro SYNC_RAM_ARB_STATS_EN defined: the block SHALL add outputs gcnt0/gcnt1 (8 bits each), each incremented on its requester's ack and saturating at 255, cleared by reset.
REQ-027 Macro SYNC_RAM_ARB_STATS_EN undefined: the gcnt ports and counters SHALL be absent; all other behaviour identical.

Structure
REQ-028 Package sync_ram_arb_pkg SHALL hold the FSM state enum (IDLE, ACCESS, RESP) and default width constants.
REQ-029 Round-robin selection SHALL be a sub-module rr_arbiter2 (req[1:0], last_owner in; grant one-hot, winner out).

Verification
REQ-030 Reset, then req0 write addr=01 data=CC -> ram_we=1, ram_addr=01, ram_din=CC in cycle 2, ack0 in cycle 3.
REQ-031 req0 read addr=01 after REQ-030 -> ram_rd=1 in cycle 2, ack0 with rdata0=CC in cycle 3; rdata1 stays 00.
REQ-032 req0 and req1 both held after reset -> service order 0,1,0,1; acks 3 cycles apart; gnt never overlaps.
REQ-033 req1 write addr=10 data=F0, req1 dropped in ACCESS -> write completes, ack1 pulses; req1 read addr=10 -> rdata1=F0.
REQ-034 Reset asserted in ACCESS -> next cycle IDLE, no ack, all outputs 0; following tie grants requester 0.
REQ-035 With SYNC_RAM_ARB_STATS_EN, 300 requester-0 transactions -> gcnt0=255, gcnt1=0.

Source files
------------

// File: rtl/sync_ram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sync_ram_arb_pkg
// Description : Shared types and constants for the two-requester synchronous
//               RAM arbiter: FSM state encoding, default bus widths and a
//               saturating increment helper for the optional grant counters.
// Revision    : 1.0 - initial release
// ============================================================================
package sync_ram_arb_pkg;

    localparam int c_default_addr_w = 2;
    localparam int c_default_data_w = 8;
    localparam int c_gcnt_w         = 8;

    // Every transaction walks IDLE -> ACCESS -> RESP -> IDLE.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [c_gcnt_w-1:0] sat_inc(input logic [c_gcnt_w-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter2
// Description : Two-way round-robin selector. On a tie the requester that did
//               not own the previous transaction wins; a lone requester always
//               wins. Purely combinational.
// Ports       : req_i[1:0]    - request vector
//               last_owner_i  - index of the previous owner
//               grant_o[1:0]  - one-hot grant (zero when no request)
//               winner_o      - index of the granted requester
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2 (
    input  logic [1:0] req_i,
    input  logic       last_owner_i,
    output logic [1:0] grant_o,
    output logic       winner_o
);

    always_comb begin
        winner_o = 1'b0;
        grant_o  = 2'b00;
        unique case (req_i)
            2'b01:   winner_o = 1'b0;
            2'b10:   winner_o = 1'b1;
            2'b11:   winner_o = ~last_owner_i;
            default: winner_o = 1'b0;
        endcase
        if (req_i != 2'b00) begin
            grant_o = winner_o ? 2'b10 : 2'b01;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sync_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sync_ram_arbiter
// Description : Round-robin arbiter letting two requesters share a single
//               synchronous RAM. Each transaction takes three cycles:
//               IDLE (sample + arbitrate), ACCESS (RAM strobe), RESP (ack).
// Ports       : clk, reset            - clock, synchronous active-high reset
//               req/we/addr/wdata 0,1 - requester command inputs
//               gnt0/gnt1             - owner flag during ACCESS and RESP
//               ack0/ack1             - one-cycle completion pulse in RESP
//               rdata0/rdata1         - last read result per requester
//               ram_*                 - shared RAM port (dout valid one cycle
//                                       after ram_rd)
//               gcnt0/gcnt1           - saturating ack counters (stats build)
// Config      : SYNC_RAM_ARB_STATS_EN adds the gcnt0/gcnt1 outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_ram_arbiter
    import sync_ram_arb_pkg::*;
#(
    parameter int ADDR_W = c_default_addr_w,
    parameter int DATA_W = c_default_data_w
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_rd,
    output logic              ram_we,
    output logic              ram_cs,
`ifdef SYNC_RAM_ARB_STATS_EN
    output logic [7:0]        gcnt0,
    output logic [7:0]        gcnt1,
`endif
    input  logic [DATA_W-1:0] ram_dout
);

    arb_state_t        state_q;
    logic              owner_q;
    logic              last_owner_q;
    logic              we_q;
    logic              gnt0_q, gnt1_q;
    logic              ack0_q, ack1_q;
    logic              ram_cs_q, ram_rd_q, ram_we_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [DATA_W-1:0] ram_din_q;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;

    logic [1:0]        w_grant;
    logic              w_winner;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic              w_rd_resp;

    rr_arbiter2 u_rr (
        .req_i        ({req1, req0}),
        .last_owner_i (last_owner_q),
        .grant_o      (w_grant),
        .winner_o     (w_winner)
    );

    assign w_sel_we    = w_winner ? we1    : we0;
    assign w_sel_addr  = w_winner ? addr1  : addr0;
    assign w_sel_wdata = w_winner ? wdata1 : wdata0;

    // The RAM returns read data during RESP; it is forwarded straight to the
    // owner's rdata so the value is visible alongside ack, and captured at the
    // end of RESP so it is held afterwards.
    assign w_rd_resp = (state_q == RESP) && !we_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            we_q         <= 1'b0;
            gnt0_q       <= 1'b0;
            gnt1_q       <= 1'b0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            ram_cs_q     <= 1'b0;
            ram_rd_q     <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_din_q    <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (req0 || req1) begin
                        // Command fields are captured here only; later input
                        // changes cannot disturb the transaction.
                        state_q    <= ACCESS;
                        owner_q    <= w_winner;
                        we_q       <= w_sel_we;
                        gnt0_q     <= w_grant[0];
                        gnt1_q     <= w_grant[1];
                        ram_cs_q   <= 1'b1;
                        ram_we_q   <= w_sel_we;
                        ram_rd_q   <= ~w_sel_we;
                        ram_addr_q <= w_sel_addr;
                        ram_din_q  <= w_sel_we ? w_sel_wdata : '0;
                    end
                end
                ACCESS: begin
                    state_q    <= RESP;
                    ram_cs_q   <= 1'b0;
                    ram_we_q   <= 1'b0;
                    ram_rd_q   <= 1'b0;
                    ram_addr_q <= '0;
                    ram_din_q  <= '0;
                    ack0_q     <= ~owner_q;
                    ack1_q     <= owner_q;
                end
                RESP: begin
                    if (!we_q) begin
                        if (owner_q) begin
                            rdata1_q <= ram_dout;
                        end else begin
                            rdata0_q <= ram_dout;
                        end
                    end
                    last_owner_q <= owner_q;
                    gnt0_q       <= 1'b0;
                    gnt1_q       <= 1'b0;
                    state_q      <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign gnt0     = gnt0_q;
    assign gnt1     = gnt1_q;
    assign ack0     = ack0_q;
    assign ack1     = ack1_q;
    assign ram_cs   = ram_cs_q;
    assign ram_rd   = ram_rd_q;
    assign ram_we   = ram_we_q;
    assign ram_addr = ram_addr_q;
    assign ram_din  = ram_din_q;
    assign rdata0   = (w_rd_resp && !owner_q) ? ram_dout : rdata0_q;
    assign rdata1   = (w_rd_resp &&  owner_q) ? ram_dout : rdata1_q;

`ifdef SYNC_RAM_ARB_STATS_EN
    logic [7:0] gcnt0_q, gcnt1_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            gcnt0_q <= '0;
            gcnt1_q <= '0;
        end else begin
            if (ack0_q) begin
                gcnt0_q <= sat_inc(gcnt0_q);
            end
            if (ack1_q) begin
                gcnt1_q <= sat_inc(gcnt1_q);
            end
        end
    end

    assign gcnt0 = gcnt0_q;
    assign gcnt1 = gcnt1_q;
`endif

endmodule
`default_nettype wire
